// File: rtl/lfsr_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module : lfsr_stream_pkg
// Brief  : Shared types, constants and parameter-legality helpers for the
//          LFSR stream UART path.
// Rev    : 1.0  initial release
// ============================================================================
package lfsr_stream_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic bit bits_per_entry_legal(input int b);
    return (b == 1) || (b == 2) || (b == 4) || (b == 8);
  endfunction

  function automatic bit clks_per_bit_legal(input int c);
    return c >= 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_uart_streamer_uart_tx.sv
`default_nettype none
// ============================================================================
// Module : uart_tx
// Brief  : 8N1 UART transmitter with byte valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx
  import lfsr_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic [UART_DATA_BITS-1:0] i_data,
  output logic                      o_ready,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam int C_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [C_CW-1:0] C_BAUD_LAST = C_CW'(CLKS_PER_BIT - 1);
  localparam int C_IW = $clog2(UART_DATA_BITS);
  localparam logic [C_IW-1:0] C_IDX_LAST = C_IW'(UART_DATA_BITS - 1);

  uart_state_t               r_state;
  uart_state_t               w_state_next;
  logic [C_CW-1:0]           r_baud;
  logic [C_IW-1:0]           r_idx;
  logic [C_IW-1:0]           w_idx_next;
  logic [UART_DATA_BITS-1:0] r_shreg;
  logic                      r_tx;
  logic                      r_busy;
  logic                      w_tx_next;
  logic                      w_baud_last;

  assign w_baud_last = (r_baud == C_BAUD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_tx_next    = 1'b1;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_state_next = START;
          w_idx_next   = '0;
        end
      end
      START: begin
        if (w_baud_last) w_state_next = DATA;
      end
      DATA: begin
        if (w_baud_last) begin
          if (r_idx == C_IDX_LAST) w_state_next = STOP;
          else                     w_idx_next   = r_idx + 1'b1;
        end
      end
      STOP: begin
        if (w_baud_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    // tx is registered, so it is driven from the state we are about to enter
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_shreg[w_idx_next];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_baud  <= ((r_state == IDLE) || w_baud_last) ? '0 : r_baud + 1'b1;
      if ((r_state == IDLE) && i_valid) r_shreg <= i_data;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

  assign o_ready      = (r_state == IDLE);
  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = (r_state == STOP) && w_baud_last;

endmodule
`default_nettype wire

// File: rtl/lfsr_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module : lfsr_uart_streamer
// Brief  : Pops LFSR FIFO entries, packs their low bits LSB-first into bytes
//          and streams them out over a UART 8N1 line.
// Rev    : 1.0  initial release
// ============================================================================
module lfsr_uart_streamer
  import lfsr_stream_pkg::*;
#(
  parameter int FIFO_WIDTH     = 8,
  parameter int BITS_PER_ENTRY = 1,
  parameter int CLKS_PER_BIT   = 868
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_data_out_valid,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           bytes_sent
);

  localparam int C_ENTRIES = UART_DATA_BITS / BITS_PER_ENTRY;
  localparam int C_CNTW    = $clog2(C_ENTRIES + 1);
  localparam logic [C_CNTW-1:0] C_CNT_FULL = C_CNTW'(C_ENTRIES);

  if (!bits_per_entry_legal(BITS_PER_ENTRY) || (BITS_PER_ENTRY > FIFO_WIDTH)) begin : g_bad_bits_per_entry
    $error("lfsr_uart_streamer: BITS_PER_ENTRY must be 1, 2, 4 or 8 and fit in FIFO_WIDTH");
  end
  if (!clks_per_bit_legal(CLKS_PER_BIT)) begin : g_bad_clks_per_bit
    $error("lfsr_uart_streamer: CLKS_PER_BIT must be at least 2");
  end

  logic                            r_pop;
  logic                            r_pending;
  logic [C_CNTW-1:0]               r_cnt;
  logic [C_CNTW-1:0]               w_cnt_next;
  logic [UART_DATA_BITS-1:0]       r_pack;
  logic [UART_DATA_BITS-1:0]       w_pack_next;
  logic [BITS_PER_ENTRY+UART_DATA_BITS-1:0] w_cat;
  logic [15:0]                     r_bytes;
  logic                            w_capture;
  logic                            w_full;
  logic                            w_ready;
  logic                            w_handoff;
  logic                            w_pending_next;
  logic                            w_pop_next;
  logic                            w_unused_data;

  assign w_capture     = fifo_data_out_valid && r_pending;
  assign w_full        = (r_cnt == C_CNT_FULL);
  assign w_handoff     = w_full && w_ready;
  assign w_unused_data = ^fifo_data_out;

  // New bits enter at the top so the first capture ends up in byte bit 0
  assign w_cat = {fifo_data_out[BITS_PER_ENTRY-1:0], r_pack};

  always_comb begin
    w_cnt_next  = r_cnt;
    w_pack_next = r_pack;
    if (w_handoff) begin
      w_cnt_next  = '0;
      w_pack_next = '0;
    end else if (w_capture) begin
      w_cnt_next  = r_cnt + 1'b1;
      w_pack_next = w_cat[BITS_PER_ENTRY +: UART_DATA_BITS];
    end
    w_pending_next = r_pop ? 1'b1 : (w_capture ? 1'b0 : r_pending);
    w_pop_next     = !fifo_empty && !w_pending_next && (w_cnt_next != C_CNT_FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pop     <= 1'b0;
      r_pending <= 1'b0;
      r_cnt     <= '0;
      r_pack    <= '0;
      r_bytes   <= '0;
    end else begin
      r_pop     <= w_pop_next;
      r_pending <= w_pending_next;
      r_cnt     <= w_cnt_next;
      r_pack    <= w_pack_next;
      if (frame_done) r_bytes <= r_bytes + 16'd1;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk          (clk),
    .rst_n        (reset_n),
    .i_valid      (w_full),
    .i_data       (r_pack),
    .o_ready      (w_ready),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  assign fifo_pop   = r_pop;
  assign bytes_sent = r_bytes;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_uart_streamer.sv
`default_nettype none
// ============================================================================
// Module : tb_lfsr_uart_streamer
// Brief  : Directed self-checking bench for lfsr_uart_streamer (CLKS_PER_BIT=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_lfsr_uart_streamer;

  logic        clk;
  logic        reset_n;
  logic        fifo_empty, fifo_pop, fifo_data_out_valid, tx, busy, frame_done;
  logic [7:0]  fifo_data_out;
  logic [15:0] bytes_sent;
  logic        fifo_empty2, fifo_pop2, fifo_data_out_valid2, tx2, busy2, frame_done2;
  logic [7:0]  fifo_data_out2;
  logic [15:0] bytes_sent2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pop_count = 0;
  int dbl_pop = 0;
  int lat = 1;
  bit outst = 0;
  bit spur = 0;
  logic [7:0] spur_d = 8'h00;

  logic [7:0] q[$];
  logic [7:0] q2[$];
  logic [2:0] pv = 3'b000;
  logic [7:0] pd0 = 8'h00, pd1 = 8'h00, pd2 = 8'h00, dq;
  logic       pv2 = 1'b0;
  logic [7:0] pdd2 = 8'h00, dq2;

  lfsr_uart_streamer #(.FIFO_WIDTH(8), .BITS_PER_ENTRY(1), .CLKS_PER_BIT(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_data_out(fifo_data_out), .fifo_data_out_valid(fifo_data_out_valid),
    .tx(tx), .busy(busy), .frame_done(frame_done), .bytes_sent(bytes_sent));

  lfsr_uart_streamer #(.FIFO_WIDTH(8), .BITS_PER_ENTRY(2), .CLKS_PER_BIT(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty2), .fifo_pop(fifo_pop2),
    .fifo_data_out(fifo_data_out2), .fifo_data_out_valid(fifo_data_out_valid2),
    .tx(tx2), .busy(busy2), .frame_done(frame_done2), .bytes_sent(bytes_sent2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model for u_dut: read latency 1 or 3 cycles, plus a spurious-valid injector
  assign fifo_empty          = (q.size() == 0);
  assign fifo_data_out_valid = spur | ((lat == 3) ? pv[2] : pv[0]);
  assign fifo_data_out       = spur ? spur_d : ((lat == 3) ? pd2 : pd0);

  always @(posedge clk) begin
    dq = 8'h00;
    if (fifo_data_out_valid && !spur) outst = 0;
    if (fifo_pop) begin
      if (outst) dbl_pop = dbl_pop + 1;
      outst = 1;
      pop_count = pop_count + 1;
      if (q.size() != 0) dq = q.pop_front();
    end
    pv  <= {pv[1:0], fifo_pop};
    pd0 <= dq;
    pd1 <= pd0;
    pd2 <= pd1;
    if (!reset_n) begin
      pv <= 3'b000;
      outst = 0;
    end
  end

  // FIFO model for u_dut2: fixed 1-cycle latency
  assign fifo_empty2          = (q2.size() == 0);
  assign fifo_data_out_valid2 = pv2;
  assign fifo_data_out2       = pdd2;

  always @(posedge clk) begin
    dq2 = 8'h00;
    if (fifo_pop2 && q2.size() != 0) dq2 = q2.pop_front();
    pv2  <= fifo_pop2 && reset_n;
    pdd2 <= dq2;
  end

  task automatic push_bits(input logic [7:0] b);
    for (int i = 0; i < 8; i++) q.push_back({7'h00, b[i]});
  endtask

  // Waits for busy, then checks every cycle of the 40-cycle frame and the idle cycle after
  task automatic check_frame(input logic [7:0] exp, input string nm, output int start_cyc, output int pops);
    bit   found;
    logic exp_tx;
    found = 0;
    start_cyc = -1;
    pops = -1;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (busy === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL %s busy_start: actual=0 required=1 within 200 cycles", nm);
      return;
    end
    start_cyc = cyc;
    pops = pop_count;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4)        exp_tx = 1'b0;
      else if (k >= 36) exp_tx = 1'b1;
      else              exp_tx = exp[(k - 4) / 4];
      n_cmp++;
      if (tx !== exp_tx || busy !== 1'b1 || frame_done !== (k == 39)) begin
        n_bad++;
        $display("FAIL %s frame_cycle%0d: actual tx=%b busy=%b done=%b required tx=%b busy=1 done=%b",
                 nm, k, tx, busy, frame_done, exp_tx, (k == 39));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s post_frame_idle: actual tx=%b busy=%b required tx=1 busy=0", nm, tx, busy);
    end
  endtask

  task automatic check_count(input string nm, input logic [15:0] exp);
    n_cmp++;
    if (bytes_sent !== exp) begin
      n_bad++;
      $display("FAIL %s bytes_sent: actual=%0d required=%0d", nm, bytes_sent, exp);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (fifo_pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || bytes_sent !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_values: actual pop=%b tx=%b busy=%b done=%b cnt=%0d required 0 1 0 0 0",
               fifo_pop, tx, busy, frame_done, bytes_sent);
    end
  endtask

  task automatic test_basic();
    int s, p;
    push_bits(8'h4D);
    check_frame(8'h4D, "basic", s, p);
    check_count("basic", 16'd1);
  endtask

  task automatic test_upper_bits();
    int s, p;
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'hFF);
      q.push_back(8'hFE);
    end
    check_frame(8'h55, "upper_bits", s, p);
    check_count("upper_bits", 16'd2);
  endtask

  task automatic test_two_bit();
    bit         found;
    logic [7:0] rx;
    logic       st, sp;
    found = 0;
    q2.push_back(8'h03);
    q2.push_back(8'h00);
    q2.push_back(8'h02);
    q2.push_back(8'h01);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (busy2 === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL two_bit busy_start: actual=0 required=1 within 200 cycles");
      return;
    end
    repeat (2) @(negedge clk);
    st = tx2;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      rx[i] = tx2;
    end
    repeat (4) @(negedge clk);
    sp = tx2;
    n_cmp++;
    if (rx !== 8'h63 || st !== 1'b0 || sp !== 1'b1) begin
      n_bad++;
      $display("FAIL two_bit byte: actual=%h start=%b stop=%b required=63 start=0 stop=1", rx, st, sp);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bytes_sent2 !== 16'd1 || busy2 !== 1'b0) begin
      n_bad++;
      $display("FAIL two_bit count: actual cnt=%0d busy=%b required cnt=1 busy=0", bytes_sent2, busy2);
    end
  endtask

  task automatic test_empty();
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL empty_fifo: actual bad_cycles=%0d required=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int p0, s1, s2, s3, p1, p2, p3;
    p0 = pop_count;
    push_bits(8'h4D);
    push_bits(8'hA5);
    push_bits(8'h0F);
    check_frame(8'h4D, "b2b_f1", s1, p1);
    check_frame(8'hA5, "b2b_f2", s2, p2);
    check_frame(8'h0F, "b2b_f3", s3, p3);
    n_cmp++;
    if (p1 - p0 != 8 || p2 - p0 != 16 || p3 - p0 != 24) begin
      n_bad++;
      $display("FAIL b2b_pops: actual %0d/%0d/%0d required 8/16/24", p1 - p0, p2 - p0, p3 - p0);
    end
    n_cmp++;
    if (s2 - s1 != 41 || s3 - s2 != 41) begin
      n_bad++;
      $display("FAIL b2b_spacing: actual %0d/%0d required 41/41", s2 - s1, s3 - s2);
    end
    check_count("b2b", 16'd5);
  endtask

  task automatic test_spurious();
    int p0, s, p;
    p0 = pop_count;
    @(negedge clk);
    spur   = 1;
    spur_d = 8'hFF;
    @(negedge clk);
    spur = 0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (pop_count != p0 || busy !== 1'b0 || tx !== 1'b1) begin
      n_bad++;
      $display("FAIL spurious_idle: actual pops=%0d busy=%b tx=%b required pops=%0d busy=0 tx=1",
               pop_count, busy, tx, p0);
    end
    push_bits(8'h4D);
    check_frame(8'h4D, "spurious", s, p);
    check_count("spurious", 16'd6);
  endtask

  task automatic test_latency3();
    int s, p;
    lat = 3;
    push_bits(8'h4D);
    check_frame(8'h4D, "latency3", s, p);
    n_cmp++;
    if (dbl_pop != 0) begin
      n_bad++;
      $display("FAIL latency3_double_pop: actual=%0d required=0", dbl_pop);
    end
    check_count("latency3", 16'd7);
    lat = 1;
  endtask

  task automatic test_reset_mid_frame();
    int  s, p;
    bit  found;
    found = 0;
    push_bits(8'h4D);
    q.push_back(8'h01);
    q.push_back(8'h01);
    q.push_back(8'h01);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (busy === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL reset_mid busy_start: actual=0 required=1 within 200 cycles");
    end
    repeat (17) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_pop !== 1'b0 || bytes_sent !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_mid_async: actual tx=%b busy=%b pop=%b cnt=%0d required 1 0 0 0",
               tx, busy, fifo_pop, bytes_sent);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    push_bits(8'hA5);
    check_frame(8'hA5, "after_reset", s, p);
    check_count("after_reset", 16'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    test_basic();
    test_upper_bits();
    test_two_bit();
    test_empty();
    test_back_to_back();
    test_spurious();
    test_latency3();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_uart_streamer.md
# lfsr_uart_streamer

Downstream consumer of the LFSR-fed FIFO. It pops FIFO entries, packs the low bits of successive entries into bytes LSB-first, and serialises each byte on a UART 8N1 line for off-board capture of the random bit stream. The FIFO's pop/data_out/data_out_valid/empty signals connect directly to this block, and `tx` drives the board UART pin.

## Interface
- `FIFO_WIDTH`, 8: width of a FIFO entry.
- `BITS_PER_ENTRY`, 1: valid LSBs taken from each entry; must be 1, 2, 4 or 8.
- `CLKS_PER_BIT`, 868: clock cycles per UART bit; must be ≥ 2.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_pop` out 1: single-cycle pop request.
- `fifo_data_out` in FIFO_WIDTH: FIFO read data.
- `fifo_data_out_valid` in 1: read data valid.
- `tx` out 1: UART serial line, idles high.
- `busy` out 1: a frame is in progress (START, DATA or STOP).
- `frame_done` out 1: one-cycle pulse in the last cycle of each stop bit.
- `bytes_sent` out 16: count of completed frames; wraps 0xFFFF→0.

## Operation
- Reset values: `fifo_pop`=0, `tx`=1, `busy`=0, `frame_done`=0, `bytes_sent`=0. Packer count is 0, the outstanding-pop flag is clear, and the holding byte is invalid.
- Pop rule: `fifo_pop` is high in a cycle only when all of these hold: `fifo_empty`=0, no pop outstanding, and the packer has not yet completed a byte. Pop sets the outstanding flag.
- Capture: a cycle with `fifo_data_out_valid`=1 while a pop is outstanding shifts `fifo_data_out[BITS_PER_ENTRY-1:0]` into the packer and clears the flag.
  - A pop may reassert in that same cycle.
  - Valid with no pop outstanding is ignored.
  - Upper entry bits are ignored.
- Packing: the first captured bit lands in byte bit 0. After 8/BITS_PER_ENTRY captures the byte is complete, and popping stalls until the byte is handed to the transmitter.
- Handoff: a complete byte and an idle transmitter transfer in the same cycle. The packer then clears and may pop again in the next cycle.
- Transmitter FSM:
  - IDLE: `tx`=1. On handoff, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: bits 0..7, each CLKS_PER_BIT cycles.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. `frame_done` pulses in its last cycle, and `bytes_sent` increments on the same edge. Then IDLE.
- IDLE lasts at least one cycle between frames.
- Reset mid-operation: all state returns to reset values immediately. Partial byte and frame are discarded, and a pop outstanding at reset is forgotten.

## Timing
- `tx`, `busy` and `fifo_pop` are registered outputs.
- Handoff at edge N: `tx` goes low and `busy` goes high after edge N, so the start bit occupies cycles N+1..N+CLKS_PER_BIT.
- Frame length is 10·CLKS_PER_BIT cycles. Back-to-back frame period is 10·CLKS_PER_BIT+1.
- With 1-cycle FIFO read latency, the pop rate is at most one per 2 cycles. Any latency ≥1 is tolerated.
- The next byte packs while the current frame transmits, so sustained throughput is limited only by the UART.

## Structure
- Package `lfsr_stream_pkg`:
  - `UART_DATA_BITS`=8.
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
  - Parameter-legality checks.
- Sub-module `uart_tx`, with byte `valid`/`ready` in and `tx`/`busy`/`frame_done` out. It contains the baud counter, bit index and FSM.
- The top level of this block holds the pop control, packer, holding byte and `bytes_sent`.

## Test plan
All scenarios use CLKS_PER_BIT=4 and a 1-cycle FIFO model unless stated.
- Basic packing: entries 1,0,1,1,0,0,1,0 → byte 0x4D. `tx` is low 4 cycles, then 1,0,1,1,0,0,1,0 at 4 cycles each, then high 4 cycles. `frame_done` pulses once and `bytes_sent`=1.
- Upper bits ignored: entries 0xFF,0xFE,0xFF,0xFE,0xFF,0xFE,0xFF,0xFE → byte 0x55. With BITS_PER_ENTRY=2, entries 0x03,0x00,0x02,0x01 → byte 0x63.
- Empty FIFO: `fifo_empty` held at 1 for 100 cycles → `fifo_pop` never asserts, `tx` stays 1 and `busy` stays 0.
- Backpressure: 24 entries preloaded → exactly 8 pops before the first handoff. The second byte is complete during frame 1, and no pop occurs until handoff. Three frames are spaced 41 cycles apart and `bytes_sent`=3.
- Protocol robustness:
  - A spurious `fifo_data_out_valid` with no pop outstanding changes nothing.
  - A 3-cycle read latency still yields a correct 0x4D, with no second pop while one is outstanding.
- Reset mid-frame: assert `reset_n`=0 during DATA bit 3 → `tx`=1, `busy`=0 and `fifo_pop`=0 immediately, without waiting for a clock edge. After release, the next 8 entries form a fresh byte.
